sram_mem_ctrl: RTL
==================

// Module: sram_mem_ctrl
// PURPOSE
//  Memory-side stage directly downstream of the SLC-3 datapath/ISDU; drives the external async SRAM.
//  Turns one-word read/write requests into timed CE/OE/WE/UB/LB sequences on the tri-state Data bus.
//  Decodes the memory-mapped I/O word: reads return the synchronized switches, writes update the hex display register.
// PARAMETERS
//  RD_WAIT   2        cycles OE held low before read data is latched (>=1)
//  WR_WAIT   2        cycles WE held low per write pulse (>=1)
//  IO_ADDR   16'hFFFF address decoded as switch/hex I/O (never reaches SRAM)
// PORTS
//  Clk        in     1   system clock, 50 MHz, all state on rising edge
//  Reset_h    in     1   synchronous, active-high reset
//  Mem_req    in     1   request; sampled only in IDLE
//  Mem_we     in     1   1=write, 0=read; captured with request
//  Mem_addr   in     16  word address; captured with request
//  Mem_wdata  in     16  write data; captured with request
//  Mem_rdata  out    16  read data; valid from Mem_ready cycle until next read completes
//  Mem_ready  out    1   one-cycle completion pulse
//  Switches   in     16  board switches, asynchronous
//  Hex_data   out    16  value shown on HEX display
//  ADDR       out    20  SRAM address = {4'h0, captured addr}
//  Data       inout  16  SRAM data bus
//  CE,UB,LB,OE,WE out 1  SRAM controls, active low
// BEHAVIOUR
//  Reset (any state, mid-op included): state=IDLE; CE=UB=LB=OE=WE=1; Data='Z; ADDR=0; Mem_ready=0; Mem_rdata=0; Hex_data=0; sync flops=0.
//  States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, IO, DONE.
//  IDLE: if Mem_req, capture addr/we/wdata; addr==IO_ADDR -> IO; else we ? WR_SETUP : RD.
//  Cycle numbering: cycle 0 = IDLE cycle with Mem_req=1.
//  Read:  cycles 1..RD_WAIT in RD (CE,OE,UB,LB low); Data latched into Mem_rdata at end of last RD cycle; cycle RD_WAIT+1 = DONE.
//  Write: cycle 1 WR_SETUP (CE low, WE high, Data driven); cycles 2..WR_WAIT+1 WR_PULSE (WE low);
//         cycle WR_WAIT+2 WR_HOLD (WE high, Data still driven); cycle WR_WAIT+3 = DONE.
//  IO: cycle 1 IO; read -> Mem_rdata<=synced Switches; write -> Hex_data<=wdata; no SRAM control asserted; cycle 2 = DONE.
//  DONE: Mem_ready=1 for exactly one cycle, all SRAM controls high, then IDLE.
//  Data driven only in WR_SETUP/WR_PULSE/WR_HOLD, 'Z otherwise; OE and WE never low in the same cycle.
//  ADDR held stable from cycle 1 through DONE; changes only on capture.
//  Mem_req while busy: ignored (no queueing). Mem_req still high in the IDLE cycle after DONE starts a new transaction;
//  requester drops Mem_req on Mem_ready.
//  Wait counter: $clog2(max(RD_WAIT,WR_WAIT))+1 bits, cleared on every state entry; no wrap.
//  Switches pass through a 2-flop synchronizer; IO read returns value at most 2 cycles old.
//  Hex_data changes only on IO write or reset; SRAM writes to other addresses never affect it.
// STRUCTURE
//  Package sram_mem_pkg: state enum typedef, IO_ADDR default constant.
//  Sub-module sync2 (parameterized width, 2-flop synchronizer) for Switches; FSM and bus logic inline.
// TESTING
//  1 Reset mid-WR_PULSE (Reset_h=1 at cycle 3) -> next cycle WE=CE=1, Data='Z, state IDLE, Mem_ready stays 0.
//  2 Write addr 16'h0031, wdata 16'hA0A0 then read 16'h0031 with SRAM model -> Mem_rdata=16'hA0A0; write Mem_ready at cycle 5, read Mem_ready at cycle 3 (defaults).
//  3 Switches=16'h0014, read IO_ADDR -> Mem_ready at cycle 2, Mem_rdata=16'h0014, CE stays 1 throughout.
//  4 Write IO_ADDR wdata 16'hFFFF -> Hex_data=16'hFFFF from cycle 2; SRAM write to 16'h0005 afterwards leaves Hex_data=16'hFFFF.
//  5 Hold Mem_req=1 continuously with reads -> back-to-back transactions, one Mem_ready pulse per 4 cycles; toggling Mem_addr mid-RD does not change ADDR.
//  6 Protocol checkers all runs: OE&WE never both low; Data driven only while WE-sequence active; Mem_ready never two consecutive cycles.

Source files
------------

// File: rtl/sram_mem_pkg.sv
// Shared types and constants for the SRAM memory controller.
// The FSM state encoding and the default I/O-mapped word address live here.
package sram_mem_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_WR_SETUP,
      ST_WR_PULSE,
      ST_WR_HOLD,
      ST_IO,
      ST_DONE
   } state_t;

   localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/sram_mem_ctrl_sync2.sv
// Two-flop synchronizer for a bus of quasi-static asynchronous inputs (board switches).
// Individual bits may resolve a cycle apart; the consumer tolerates that.
module sync2 #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             srst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_reg;
   logic [WIDTH-1:0] sync_reg;

   always_ff @(posedge clk) begin
      if (srst) begin
         meta_reg <= '0;
         sync_reg <= '0;
      end else begin
         meta_reg <= d;
         sync_reg <= meta_reg;
      end
   end

   assign q = sync_reg;

endmodule

// File: rtl/sram_mem_ctrl.sv
// Turns single-word read/write requests into timed async-SRAM control sequences,
// and decodes one word address as the switch (read) / hex display (write) I/O port.
module sram_mem_ctrl
   import sram_mem_pkg::*;
#(
   parameter int          RD_WAIT = 2,
   parameter int          WR_WAIT = 2,
   parameter logic [15:0] IO_ADDR = IO_ADDR_DEFAULT
) (
   input  logic        Clk,
   input  logic        Reset_h,
   input  logic        Mem_req,
   input  logic        Mem_we,
   input  logic [15:0] Mem_addr,
   input  logic [15:0] Mem_wdata,
   output logic [15:0] Mem_rdata,
   output logic        Mem_ready,
   input  logic [15:0] Switches,
   output logic [15:0] Hex_data,
   output logic [19:0] ADDR,
   inout  wire  [15:0] Data,
   output logic        CE,
   output logic        UB,
   output logic        LB,
   output logic        OE,
   output logic        WE
);

   localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
   localparam int CNT_W    = $clog2(MAX_WAIT) + 1;
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_WAIT - 1);
   localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_WAIT - 1);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg;
   logic [15:0]      addr_reg;
   logic             we_reg;
   logic [15:0]      wdata_reg;
   logic [15:0]      rdata_reg;
   logic [15:0]      hex_reg;
   logic [15:0]      sw_sync;
   logic             drive_data;

   sync2 #(.WIDTH(16)) u_sw_sync (
      .clk  (Clk),
      .srst (Reset_h),
      .d    (Switches),
      .q    (sw_sync)
   );

   always_ff @(posedge Clk) begin
      if (Reset_h) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         addr_reg  <= '0;
         we_reg    <= 1'b0;
         wdata_reg <= '0;
         rdata_reg <= '0;
         hex_reg   <= '0;
      end else begin
         state_reg <= state_next;
         // Counter restarts on every state change and saturates instead of wrapping.
         if (state_next != state_reg)
            cnt_reg <= '0;
         else if (cnt_reg != '1)
            cnt_reg <= cnt_reg + 1'b1;

         if (state_reg == ST_IDLE && Mem_req) begin
            addr_reg  <= Mem_addr;
            we_reg    <= Mem_we;
            wdata_reg <= Mem_wdata;
         end

         if (state_reg == ST_RD && cnt_reg == RD_LAST)
            rdata_reg <= Data;
         if (state_reg == ST_IO && !we_reg)
            rdata_reg <= sw_sync;
         if (state_reg == ST_IO && we_reg)
            hex_reg <= wdata_reg;
      end
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         ST_IDLE: begin
            if (Mem_req) begin
               if (Mem_addr == IO_ADDR) state_next = ST_IO;
               else if (Mem_we)         state_next = ST_WR_SETUP;
               else                     state_next = ST_RD;
            end
         end
         ST_RD:       if (cnt_reg == RD_LAST) state_next = ST_DONE;
         ST_WR_SETUP: state_next = ST_WR_PULSE;
         ST_WR_PULSE: if (cnt_reg == WR_LAST) state_next = ST_WR_HOLD;
         ST_WR_HOLD:  state_next = ST_DONE;
         ST_IO:       state_next = ST_DONE;
         ST_DONE:     state_next = ST_IDLE;
         default:     state_next = ST_IDLE;
      endcase
   end

   // Controls decode straight from state; OE and WE belong to disjoint states so never overlap.
   always_comb begin
      CE         = 1'b1;
      UB         = 1'b1;
      LB         = 1'b1;
      OE         = 1'b1;
      WE         = 1'b1;
      drive_data = 1'b0;
      Mem_ready  = 1'b0;
      unique case (state_reg)
         ST_RD: begin
            CE = 1'b0;
            UB = 1'b0;
            LB = 1'b0;
            OE = 1'b0;
         end
         ST_WR_SETUP, ST_WR_HOLD: begin
            CE         = 1'b0;
            UB         = 1'b0;
            LB         = 1'b0;
            drive_data = 1'b1;
         end
         ST_WR_PULSE: begin
            CE         = 1'b0;
            UB         = 1'b0;
            LB         = 1'b0;
            WE         = 1'b0;
            drive_data = 1'b1;
         end
         ST_DONE: Mem_ready = 1'b1;
         default: ;
      endcase
   end

   assign Data      = drive_data ? wdata_reg : 16'bz;
   assign ADDR      = {4'h0, addr_reg};
   assign Mem_rdata = rdata_reg;
   assign Hex_data  = hex_reg;

endmodule
